// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem_addr, and queues {pc, instr} pairs in a prefetch FIFO.
// Optional FETCH_STATS_EN adds fetch_cnt/stall_cnt counters.
module if_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pc_write,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
`ifdef FETCH_STATS_EN
   output logic [31:0]              fetch_cnt,
   output logic [31:0]              stall_cnt,
`endif
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = AW + 1;

   logic [31:0]   pc_q, pc_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic full;
   logic push;
   logic pop;

   // Handshake: decode takes the head when out_valid & out_ready, but only in a
   // cycle that is neither frozen (pc_write=0) nor redirected.
   assign full      = (occ_q == OW'(DEPTH));
   assign out_valid = (occ_q != '0);
   assign pop       = out_valid & out_ready & pc_write & ~redirect_valid;
   assign push      = pc_write & ~redirect_valid & (~full | pop);

   assign imem_addr = pc_q;
   assign occupancy = occ_q;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;

   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (redirect_valid) begin
         // Flush everything and restart word-aligned at the target.
         pc_d     = redirect_pc & 32'hFFFF_FFFC;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + 32'(PC_STEP);
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset: outputs are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= pc_q;
         instr_mem_q[wr_ptr_q] <= imem_data;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        stall;

   assign stall     = ~redirect_valid & (~pc_write | (full & ~pop));
   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (push)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for streaming/backpressure/freeze/redirect,
// plus hand sequences for PC wrap and asynchronous reset.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  occupancy;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] fetch_cnt_w;
   logic [31:0] stall_cnt_w;
`endif

   logic        rst_w;
   logic [31:0] imem_addr_w;
   logic [31:0] imem_data_w;
   logic        out_valid_w;
   logic [31:0] out_instr_w;
   logic [31:0] out_pc_w;
   logic [2:0]  occupancy_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instruction memory: word at byte address n holds n.
   assign imem_data   = imem_addr;
   assign imem_data_w = imem_addr_w;

   if_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
`ifdef FETCH_STATS_EN
      .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
      .occupancy(occupancy)
   );

   if_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_dut_wrap (
      .clk(clk), .rst(rst_w), .pc_write(1'b1), .redirect_valid(1'b0),
      .redirect_pc(32'h0000_0000), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
      .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w), .out_pc(out_pc_w),
`ifdef FETCH_STATS_EN
      .fetch_cnt(fetch_cnt_w), .stall_cnt(stall_cnt_w),
`endif
      .occupancy(occupancy_w)
   );

   typedef struct {
      logic        pw;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [2:0]  e_occ;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic pw, logic rv, logic [31:0] rpc, logic rdy,
                               logic [31:0] e_addr, logic e_valid, logic [31:0] e_pc,
                               logic [2:0] e_occ);
      vec_t v;
      v.pw = pw; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_occ = e_occ;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      rst_w          = 1'b1;
      pc_write       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b1;

      // Expected values are the state seen during the cycle in which the inputs apply.
      //               pw   rv   rpc           rdy   addr          v    pc            occ
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h000, 1'b0, 32'h000, 3'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h004, 1'b1, 32'h000, 3'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h008, 1'b1, 32'h004, 3'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h00C, 1'b1, 32'h008, 3'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h010, 1'b1, 32'h008, 3'd2));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h014, 1'b1, 32'h008, 3'd3));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h018, 1'b1, 32'h008, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h018, 1'b1, 32'h008, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h018, 1'b1, 32'h008, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h018, 1'b1, 32'h008, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h01C, 1'b1, 32'h00C, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h020, 1'b1, 32'h010, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h024, 1'b1, 32'h014, 3'd4));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,     1'b1, 32'h028, 1'b1, 32'h018, 3'd4));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,     1'b1, 32'h028, 1'b1, 32'h018, 3'd4));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,     1'b1, 32'h028, 1'b1, 32'h018, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h028, 1'b1, 32'h018, 3'd4));
      vecs.push_back(mk(1'b1, 1'b1, 32'h200,   1'b1, 32'h02C, 1'b1, 32'h01C, 3'd4));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h200, 1'b0, 32'h000, 3'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h204, 1'b1, 32'h200, 3'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h208, 1'b1, 32'h200, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 32'h103,   1'b1, 32'h20C, 1'b1, 32'h200, 3'd3));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h100, 1'b0, 32'h000, 3'd0));
      vecs.push_back(mk(1'b1, 1'b1, 32'h300,   1'b1, 32'h104, 1'b1, 32'h100, 3'd1));
      vecs.push_back(mk(1'b1, 1'b1, 32'h401,   1'b1, 32'h300, 1'b0, 32'h000, 3'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h400, 1'b0, 32'h000, 3'd0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b1, 32'h404, 1'b1, 32'h400, 3'd1));
      vecs.push_back(mk(1'b1, 1'b0, 32'h0,     1'b0, 32'h408, 1'b1, 32'h404, 3'd1));

      step();
      step();
      rst = 1'b0;
      chk("reset_imem_addr", imem_addr, 32'h0);
      chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
      chk("reset_out_instr", out_instr, 32'h0);
      chk("reset_occupancy", {29'b0, occupancy}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         pc_write       = vecs[i].pw;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         out_ready      = vecs[i].rdy;
         chk($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].e_pc);
         chk($sformatf("v%0d_occupancy", i), {29'b0, occupancy}, {29'b0, vecs[i].e_occ});
         step();
      end

      // Asynchronous reset mid-cycle with two entries queued.
      chk("pre_rst_occupancy", {29'b0, occupancy}, 32'd2);
      chk("pre_rst_out_pc", out_pc, 32'h404);
`ifdef FETCH_STATS_EN
      chk("pre_rst_fetch_cnt", fetch_cnt, 32'd18);
      chk("pre_rst_stall_cnt", stall_cnt, 32'd6);
`endif
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("async_rst_imem_addr", imem_addr, 32'h0);
      chk("async_rst_occupancy", {29'b0, occupancy}, 32'h0);
      chk("async_rst_out_pc", out_pc, 32'h0);
`ifdef FETCH_STATS_EN
      chk("async_rst_fetch_cnt", fetch_cnt, 32'h0);
      chk("async_rst_stall_cnt", stall_cnt, 32'h0);
`endif
      step();
      rst = 1'b0;

      // PC wrap from RESET_PC = FFFF_FFF8 with continuous draining.
      step();
      rst_w = 1'b0;
      chk("wrap_c0_imem_addr", imem_addr_w, 32'hFFFF_FFF8);
      chk("wrap_c0_out_valid", {31'b0, out_valid_w}, 32'h0);
      step();
      chk("wrap_c1_out_pc", out_pc_w, 32'hFFFF_FFF8);
      chk("wrap_c1_imem_addr", imem_addr_w, 32'hFFFF_FFFC);
      step();
      chk("wrap_c2_out_pc", out_pc_w, 32'hFFFF_FFFC);
      chk("wrap_c2_imem_addr", imem_addr_w, 32'h0000_0000);
      step();
      chk("wrap_c3_out_pc", out_pc_w, 32'h0000_0000);
      chk("wrap_c3_out_instr", out_instr_w, 32'h0000_0000);
      chk("wrap_c3_out_valid", {31'b0, out_valid_w}, 32'h1);
      step();
      chk("wrap_c4_out_pc", out_pc_w, 32'h0000_0004);
      chk("wrap_c4_occupancy", {29'b0, occupancy_w}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
